// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the CPU load/store
// port (C) and the debug/DMA loader port (D). One access per cycle, single-cycle
// grant, read data returned one cycle after the grant to the requester that won.
//
// Ports
//   clk, res               clock, asynchronous active-low reset
//   c_req/c_we/c_addr/c_wdata   CPU request inputs
//   c_gnt                  CPU access issued this cycle (combinational)
//   c_rvalid/c_rdata       CPU read return
//   d_*                    same set for the debug/DMA requester
//   m_en/m_we/m_addr/m_wdata    memory access (combinational from the winner)
//   m_rdata                memory read data, valid the cycle after a read strobe
//   c_cnt/d_cnt            saturating counts of granted accesses
//
// Configuration
//   CPU_PRIORITY_EN  defined: C wins ties, D is force-granted after MAX_WAIT
//                    consecutive denied cycles. Undefined: round-robin on ties.
module dmem_arbiter #(
    parameter int unsigned ADDR_W   = 6,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              res,

    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,

    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,

    output logic [CNT_W-1:0]  c_cnt,
    output logic [CNT_W-1:0]  d_cnt
);

    // rd_own encoding: 0 = C, 1 = D
    localparam logic OWN_C = 1'b0;
    localparam logic OWN_D = 1'b1;

    logic             rd_pend_q, rd_pend_d;
    logic             rd_own_q,  rd_own_d;
    logic [CNT_W-1:0] c_cnt_q,   c_cnt_d;
    logic [CNT_W-1:0] d_cnt_q,   d_cnt_d;
    logic             c_wins_tie;

`ifdef CPU_PRIORITY_EN
    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

    // C keeps ties unless D has been starved for MAX_WAIT cycles
    always_comb begin
        c_wins_tie = (wait_cnt_q != WAIT_W'(MAX_WAIT));
    end

    // Consecutive cycles D was asking but lost
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!d_req || d_gnt) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != WAIT_W'(MAX_WAIT)) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    // last_win encoding: 0 = C, 1 = D; resets to D so C takes the first tie
    logic last_win_q, last_win_d;

    always_comb begin
        c_wins_tie = (last_win_q == OWN_D);
    end

    always_comb begin
        last_win_d = last_win_q;
        if (c_gnt) begin
            last_win_d = OWN_C;
        end else if (d_gnt) begin
            last_win_d = OWN_D;
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            last_win_q <= OWN_D;
        end else begin
            last_win_q <= last_win_d;
        end
    end
`endif

    // Grant and memory mux; nothing is granted while reset is held
    always_comb begin
        c_gnt   = 1'b0;
        d_gnt   = 1'b0;
        m_en    = 1'b0;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        if (res) begin
            c_gnt = c_req && (!d_req || c_wins_tie);
            d_gnt = d_req && (!c_req || !c_wins_tie);
        end
        if (c_gnt) begin
            m_en    = 1'b1;
            m_we    = c_we;
            m_addr  = c_addr;
            m_wdata = c_wdata;
        end else if (d_gnt) begin
            m_en    = 1'b1;
            m_we    = d_we;
            m_addr  = d_addr;
            m_wdata = d_wdata;
        end
    end

    // Track which requester owns the read returning next cycle
    always_comb begin
        rd_pend_d = m_en && !m_we;
        rd_own_d  = rd_own_q;
        if (m_en && !m_we) begin
            rd_own_d = d_gnt ? OWN_D : OWN_C;
        end
    end

    // Saturating grant counters
    always_comb begin
        c_cnt_d = c_cnt_q;
        d_cnt_d = d_cnt_q;
        if (c_gnt && (c_cnt_q != {CNT_W{1'b1}})) begin
            c_cnt_d = c_cnt_q + CNT_W'(1);
        end
        if (d_gnt && (d_cnt_q != {CNT_W{1'b1}})) begin
            d_cnt_d = d_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            rd_pend_q <= 1'b0;
            rd_own_q  <= OWN_C;
            c_cnt_q   <= '0;
            d_cnt_q   <= '0;
        end else begin
            rd_pend_q <= rd_pend_d;
            rd_own_q  <= rd_own_d;
            c_cnt_q   <= c_cnt_d;
            d_cnt_q   <= d_cnt_d;
        end
    end

    // Read return: memory data goes only to the owner, the other side sees 0
    always_comb begin
        c_rvalid = rd_pend_q && (rd_own_q == OWN_C);
        d_rvalid = rd_pend_q && (rd_own_q == OWN_D);
        c_rdata  = c_rvalid ? m_rdata : '0;
        d_rdata  = d_rvalid ? m_rdata : '0;
        c_cnt    = c_cnt_q;
        d_cnt    = d_cnt_q;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 16;

    typedef struct packed {
        logic [31:0]       due;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              res;
    logic              c_req, c_we, d_req, d_we;
    logic [ADDR_W-1:0] c_addr, d_addr;
    logic [DATA_W-1:0] c_wdata, d_wdata;
    logic              c_gnt, c_rvalid, d_gnt, d_rvalid;
    logic [DATA_W-1:0] c_rdata, d_rdata;
    logic              m_en, m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;
    logic [CNT_W-1:0]  c_cnt, d_cnt;

    logic              s_c_gnt, s_c_rvalid, s_d_gnt, s_d_rvalid, s_m_en, s_m_we;
    logic [DATA_W-1:0] s_c_rdata, s_d_rdata, s_m_wdata;
    logic [ADDR_W-1:0] s_m_addr;
    logic [1:0]        s_c_cnt, s_d_cnt;

    logic [DATA_W-1:0] mem     [64];
    logic [DATA_W-1:0] ref_mem [64];
    exp_t              exp_c[$];
    exp_t              exp_d[$];
    logic [31:0]       cyc = 0;
    int                n_checks = 0;
    int                n_pass = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(4), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .res(res),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
        .c_cnt(c_cnt), .d_cnt(d_cnt)
    );

    // Narrow-counter instance sharing the same inputs
    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(4), .CNT_W(2)) u_sat (
        .clk(clk), .res(res),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(s_c_gnt), .c_rvalid(s_c_rvalid), .c_rdata(s_c_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(s_d_gnt), .d_rvalid(s_d_rvalid), .d_rdata(s_d_rdata),
        .m_en(s_m_en), .m_we(s_m_we), .m_addr(s_m_addr), .m_wdata(s_m_wdata), .m_rdata(m_rdata),
        .c_cnt(s_c_cnt), .d_cnt(s_d_cnt)
    );

    // Behavioural single-port memory
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (m_en) begin
            if (m_we) mem[m_addr] <= m_wdata;
            else      m_rdata     <= mem[m_addr];
        end
    end

    // Scoreboard: every expected return must appear exactly in its due cycle
    always @(negedge clk) begin
        if (exp_c.size() != 0 && exp_c[0].due == cyc) begin
            exp_t e;
            e = exp_c.pop_front();
            n_checks++;
            if (c_rvalid !== 1'b1 || c_rdata !== e.data) begin
                $display("FAIL c_return: rvalid=%b rdata=%h, need rvalid=1 rdata=%h", c_rvalid, c_rdata, e.data);
            end else n_pass++;
        end else if (c_rvalid !== 1'b0) begin
            n_checks++;
            $display("FAIL c_rvalid_spurious: rvalid=%b, need 0 (cycle %0d)", c_rvalid, cyc);
        end
        if (exp_d.size() != 0 && exp_d[0].due == cyc) begin
            exp_t e;
            e = exp_d.pop_front();
            n_checks++;
            if (d_rvalid !== 1'b1 || d_rdata !== e.data) begin
                $display("FAIL d_return: rvalid=%b rdata=%h, need rvalid=1 rdata=%h", d_rvalid, d_rdata, e.data);
            end else n_pass++;
        end else if (d_rvalid !== 1'b0) begin
            n_checks++;
            $display("FAIL d_rvalid_spurious: rvalid=%b, need 0 (cycle %0d)", d_rvalid, cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic idle_inputs();
        c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        idle_inputs();
        res = 1'b0;
        repeat (2) @(posedge clk);
        #1 res = 1'b1;
    endtask

    task automatic test_reset();
        res = 1'b0;
        idle_inputs();
        c_req = 1'b1; d_req = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if ({c_gnt, d_gnt, m_en} !== 3'b000) $display("FAIL reset_gnt: c_gnt,d_gnt,m_en=%b, need 000", {c_gnt, d_gnt, m_en});
        else n_pass++;
        n_checks++;
        if ({c_rvalid, d_rvalid} !== 2'b00) $display("FAIL reset_rvalid: %b, need 00", {c_rvalid, d_rvalid});
        else n_pass++;
        n_checks++;
        if (c_cnt !== '0 || d_cnt !== '0) $display("FAIL reset_cnt: c_cnt=%0d d_cnt=%0d, need 0 0", c_cnt, d_cnt);
        else n_pass++;
        @(posedge clk); #1;
        idle_inputs();
        res = 1'b1;
    endtask

    task automatic test_c_read();
        @(posedge clk); #1;
        c_req = 1'b1; c_we = 1'b0; c_addr = 6'd5;
        #1;
        n_checks++;
        if ({c_gnt, d_gnt, m_en, m_we} !== 4'b1010 || m_addr !== 6'd5)
            $display("FAIL c_read_gnt: gnt/en/we=%b addr=%0d, need 1010 addr=5", {c_gnt, d_gnt, m_en, m_we}, m_addr);
        else n_pass++;
        exp_c.push_back('{due: cyc + 1, data: ref_mem[5]});
        @(posedge clk); #1;
        idle_inputs();
        #1;
        n_checks++;
        if (c_rvalid !== 1'b1 || c_rdata !== 32'h0000_1234 || d_rvalid !== 1'b0)
            $display("FAIL c_read_data: rvalid=%b rdata=%h d_rvalid=%b, need 1 00001234 0", c_rvalid, c_rdata, d_rvalid);
        else n_pass++;
        n_checks++;
        if (m_en !== 1'b0 || m_we !== 1'b0 || c_cnt !== 16'd1)
            $display("FAIL c_read_idle: m_en=%b m_we=%b c_cnt=%0d, need 0 0 1", m_en, m_we, c_cnt);
        else n_pass++;
        @(posedge clk);
    endtask

    task automatic test_d_write_c_read();
        apply_reset();
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 6'd10; d_wdata = 32'hDEAD_BEEF;
        #1;
        n_checks++;
        if ({c_gnt, d_gnt, m_en, m_we} !== 4'b0111 || m_addr !== 6'd10 || m_wdata !== 32'hDEAD_BEEF)
            $display("FAIL d_write_gnt: gnt/en/we=%b addr=%0d wdata=%h, need 0111 10 deadbeef",
                     {c_gnt, d_gnt, m_en, m_we}, m_addr, m_wdata);
        else n_pass++;
        ref_mem[10] = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        idle_inputs();
        c_req = 1'b1; c_addr = 6'd10;
        #1;
        n_checks++;
        if (c_gnt !== 1'b1 || d_rvalid !== 1'b0) $display("FAIL c_read10_gnt: c_gnt=%b d_rvalid=%b, need 1 0", c_gnt, d_rvalid);
        else n_pass++;
        exp_c.push_back('{due: cyc + 1, data: ref_mem[10]});
        @(posedge clk); #1;
        idle_inputs();
        #1;
        n_checks++;
        if (c_rdata !== 32'hDEAD_BEEF) $display("FAIL c_read10_data: rdata=%h, need deadbeef", c_rdata);
        else n_pass++;
        n_checks++;
        if (c_cnt !== 16'd1 || d_cnt !== 16'd1) $display("FAIL dw_cr_cnt: c_cnt=%0d d_cnt=%0d, need 1 1", c_cnt, d_cnt);
        else n_pass++;
        @(posedge clk);
    endtask

    task automatic test_back_to_back();
        int n;
        logic c_win;
`ifdef CPU_PRIORITY_EN
        n = 10;
`else
        n = 6;
`endif
        apply_reset();
        @(posedge clk); #1;
        c_req = 1'b1; c_addr = 6'd5;
        d_req = 1'b1; d_addr = 6'd10;
        for (int i = 0; i < n; i++) begin
            if (i != 0) begin
                @(posedge clk); #1;
            end
            #1;
`ifdef CPU_PRIORITY_EN
            c_win = ((i % 5) != 4);
`else
            c_win = ((i % 2) == 0);
`endif
            n_checks++;
            if ({c_gnt, d_gnt} !== {c_win, !c_win} || m_addr !== (c_win ? 6'd5 : 6'd10))
                $display("FAIL b2b_grant[%0d]: c_gnt=%b d_gnt=%b addr=%0d, need %b %b %0d",
                         i, c_gnt, d_gnt, m_addr, c_win, !c_win, c_win ? 5 : 10);
            else n_pass++;
            if (c_win) exp_c.push_back('{due: cyc + 1, data: ref_mem[5]});
            else       exp_d.push_back('{due: cyc + 1, data: ref_mem[10]});
        end
        @(posedge clk); #1;
        idle_inputs();
        #1;
        n_checks++;
`ifdef CPU_PRIORITY_EN
        if (c_cnt !== 16'd8 || d_cnt !== 16'd2) $display("FAIL b2b_cnt: c_cnt=%0d d_cnt=%0d, need 8 2", c_cnt, d_cnt);
`else
        if (c_cnt !== 16'd3 || d_cnt !== 16'd3) $display("FAIL b2b_cnt: c_cnt=%0d d_cnt=%0d, need 3 3", c_cnt, d_cnt);
`endif
        else n_pass++;
        @(posedge clk);
    endtask

    task automatic test_reset_mid_read();
        apply_reset();
        @(posedge clk); #1;
        c_req = 1'b1; c_addr = 6'd5;
        #1;
        n_checks++;
        if (c_gnt !== 1'b1) $display("FAIL midrd_gnt: c_gnt=%b, need 1", c_gnt);
        else n_pass++;
        @(posedge clk); #1;
        res = 1'b0;
        idle_inputs();
        #1;
        n_checks++;
        if (c_rvalid !== 1'b0 || c_rdata !== '0) $display("FAIL midrd_drop: rvalid=%b rdata=%h, need 0 0", c_rvalid, c_rdata);
        else n_pass++;
        @(posedge clk); #1;
        res = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            n_checks++;
            if (c_rvalid !== 1'b0 || c_cnt !== '0) $display("FAIL midrd_after[%0d]: rvalid=%b c_cnt=%0d, need 0 0", i, c_rvalid, c_cnt);
            else n_pass++;
        end
    endtask

    task automatic test_saturate();
        logic [1:0] need;
        apply_reset();
        @(posedge clk); #1;
        c_req = 1'b1; c_addr = 6'd5;
        for (int i = 0; i < 5; i++) begin
            if (i != 0) begin
                @(posedge clk); #1;
            end
            #1;
            need = (i > 3) ? 2'd3 : 2'(i);
            n_checks++;
            if (s_c_cnt !== need) $display("FAIL sat_cnt[%0d]: c_cnt=%0d, need %0d", i, s_c_cnt, need);
            else n_pass++;
            exp_c.push_back('{due: cyc + 1, data: ref_mem[5]});
        end
        @(posedge clk); #1;
        idle_inputs();
        #1;
        n_checks++;
        if (s_c_cnt !== 2'd3 || c_cnt !== 16'd5) $display("FAIL sat_final: narrow=%0d wide=%0d, need 3 5", s_c_cnt, c_cnt);
        else n_pass++;
        @(posedge clk);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i]     = 32'hA5A5_0000 ^ 32'(i * 7);
            ref_mem[i] = 32'hA5A5_0000 ^ 32'(i * 7);
        end
        mem[5]     = 32'h0000_1234;
        ref_mem[5] = 32'h0000_1234;
        m_rdata    = '0;

        test_reset();
        test_c_read();
        test_d_write_c_read();
        test_back_to_back();
        test_reset_mid_read();
        test_saturate();

        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (exp_c.size() != 0 || exp_d.size() != 0)
            $display("FAIL sb_drain: %0d C and %0d D returns outstanding, need 0 0", exp_c.size(), exp_d.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
